// File: rtl/hall_emulator_pkg.sv
// rtl/hall_emulator_pkg.sv - shared motor definitions: hall commutation table, illegal codes, fault modes
package hall_emulator_pkg;

  localparam logic [2:0] HALL_ALL_LOW  = 3'b000;
  localparam logic [2:0] HALL_ALL_HIGH = 3'b111;

  localparam logic [1:0] FAULT_NONE   = 2'b00;
  localparam logic [1:0] FAULT_LOW    = 2'b01;
  localparam logic [1:0] FAULT_HIGH   = 2'b10;
  localparam logic [1:0] FAULT_FREEZE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FORCED,
    ST_FROZEN
  } emu_state_t;

  // Forward commutation order; the hall decoder uses the same table.
  function automatic logic [2:0] hall_code(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = 3'b001;
      3'd1:    code = 3'b011;
      3'd2:    code = 3'b010;
      3'd3:    code = 3'b110;
      3'd4:    code = 3'b100;
      3'd5:    code = 3'b101;
      default: code = 3'b001;
    endcase
    return code;
  endfunction

  function automatic logic [2:0] step_index(input logic [2:0] idx, input logic fwd);
    logic [2:0] nxt;
    if (fwd) nxt = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    else     nxt = (idx == 3'd0) ? 3'd5 : idx - 3'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/hall_emulator_hall_step_timer.sv
// rtl/hall_emulator_hall_step_timer.sv - hall_step_timer: period counter, shadow period and terminal-count pulse
module hall_step_timer
  #(parameter int PERIOD_WIDTH = 16)
  (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_run,
  input  logic                    i_hold,
  input  logic                    i_restart,
  input  logic [PERIOD_WIDTH-1:0] i_period,
  output logic                    o_tc
  );

  logic [PERIOD_WIDTH-1:0] r_cnt;
  logic [PERIOD_WIDTH-1:0] r_shadow;
  logic                    r_armed;
  logic [PERIOD_WIDTH-1:0] w_cnt;
  logic [PERIOD_WIDTH-1:0] w_per;
  logic                    w_armed;

  // Until the shadow is armed on the first running cycle, the live period is used directly.
  assign w_cnt   = i_restart ? '0 : r_cnt;
  assign w_armed = r_armed & ~i_restart;
  assign w_per   = w_armed ? r_shadow : i_period;
  assign o_tc    = i_run && (w_cnt == w_per - PERIOD_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_armed  <= 1'b0;
    end else if (!i_hold) begin
      if (!i_run) begin
        r_cnt   <= '0;
        r_armed <= 1'b0;
      end else if (o_tc) begin
        r_cnt    <= '0;
        r_shadow <= i_period;
        r_armed  <= 1'b1;
      end else begin
        r_cnt <= w_cnt + PERIOD_WIDTH'(1);
        if (!w_armed) begin
          r_shadow <= i_period;
          r_armed  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hall_emulator.sv
// rtl/hall_emulator.sv - hall sensor sequence emulator with fault injection; HALL_EMU_BOUNCE_EN adds contact bounce
module hall_emulator
  import hall_emulator_pkg::*;
  #(
  parameter int PERIOD_WIDTH  = 16,
  parameter int COUNT_WIDTH   = 16,
  parameter int BOUNCE_CYCLES = 4
  )
  (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    dir,
  input  logic [PERIOD_WIDTH-1:0] step_period,
  input  logic [1:0]              fault_mode,
  output logic [2:0]              hall,
  output logic                    step_strobe,
  output logic [COUNT_WIDTH-1:0]  step_count
  );

`ifdef HALL_EMU_BOUNCE_EN
  localparam bit BOUNCE_EN = 1'b1;
`else
  localparam bit BOUNCE_EN = 1'b0;
`endif
  localparam int                BW         = $clog2(BOUNCE_CYCLES + 2);
  localparam logic [PERIOD_WIDTH:0] BOUNCE_MIN = (PERIOD_WIDTH + 1)'(BOUNCE_CYCLES + 1);

  emu_state_t       r_state;
  emu_state_t       w_state;
  logic             w_run;
  logic             w_hold;
  logic             w_restart;
  logic             w_step;
  logic             w_bounce_ok;
  logic [2:0]       w_idx_next;
  logic [2:0]       r_idx;
  logic [2:0]       r_hall;
  logic [2:0]       r_old;
  logic [BW-1:0]    r_bnc;
  logic             r_strobe;
  logic [COUNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state;
  end

  always_comb begin
    w_state = ST_IDLE;
    if (fault_mode == FAULT_FREEZE)
      w_state = ST_FROZEN;
    else if (fault_mode != FAULT_NONE)
      w_state = ST_FORCED;
    else if (en && (step_period != '0))
      w_state = ST_RUN;
    w_run     = (w_state == ST_RUN);
    w_hold    = (w_state == ST_FROZEN);
    // A freeze keeps the counter, but leaving it still restarts the period from zero.
    w_restart = (r_state == ST_FROZEN);
  end

  hall_step_timer #(.PERIOD_WIDTH(PERIOD_WIDTH)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_run     (w_run),
    .i_hold    (w_hold),
    .i_restart (w_restart),
    .i_period  (step_period),
    .o_tc      (w_step)
  );

  assign w_idx_next  = step_index(r_idx, dir);
  // Bounce must settle before the next step can arrive.
  assign w_bounce_ok = BOUNCE_EN && ({1'b0, step_period} > BOUNCE_MIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= 3'd0;
      r_hall   <= 3'b001;
      r_old    <= 3'b001;
      r_bnc    <= '0;
      r_strobe <= 1'b0;
      r_count  <= '0;
    end else begin
      r_strobe <= w_step;
      if (w_state == ST_FORCED) begin
        r_hall <= (fault_mode == FAULT_LOW) ? HALL_ALL_LOW : HALL_ALL_HIGH;
        r_bnc  <= '0;
      end else if (w_state == ST_RUN) begin
        if (w_step) begin
          r_idx   <= w_idx_next;
          r_hall  <= hall_code(w_idx_next);
          r_old   <= r_hall;
          r_bnc   <= w_bounce_ok ? BW'(BOUNCE_CYCLES) : '0;
          r_count <= r_count + (dir ? COUNT_WIDTH'(1) : {COUNT_WIDTH{1'b1}});
        end else if (r_bnc != '0) begin
          r_hall <= r_old;
          r_bnc  <= r_bnc - BW'(1);
        end else begin
          r_hall <= hall_code(r_idx);
        end
      end else if (w_state == ST_IDLE) begin
        r_hall <= hall_code(r_idx);
        r_bnc  <= '0;
      end
    end
  end

  assign hall        = r_hall;
  assign step_strobe = r_strobe;
  assign step_count  = r_count;

endmodule

// File: tb/tb_hall_emulator.sv
// tb/tb_hall_emulator.sv - directed self-checking bench for hall_emulator
module tb_hall_emulator;

  logic        clk;
  logic        rst;
  logic        en;
  logic        dir;
  logic [15:0] step_period;
  logic [1:0]  fault_mode;
  logic [2:0]  hall;
  logic        step_strobe;
  logic [15:0] step_count;

  int n_checks;
  int n_errors;

`ifdef HALL_EMU_BOUNCE_EN
  localparam bit TB_BOUNCE = 1'b1;
`else
  localparam bit TB_BOUNCE = 1'b0;
`endif

  hall_emulator #(.PERIOD_WIDTH(16), .COUNT_WIDTH(16), .BOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .dir         (dir),
    .step_period (step_period),
    .fault_mode  (fault_mode),
    .hall        (hall),
    .step_strobe (step_strobe),
    .step_count  (step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    en = 1'b0; dir = 1'b1; step_period = 16'd0; fault_mode = 2'b00;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_checks++;
    if (hall !== 3'b001 || step_strobe !== 1'b0 || step_count !== 16'd0) begin
      n_errors++;
      $display("FAIL reset: hall=%b strobe=%b count=%0d, want hall=001 strobe=0 count=0", hall, step_strobe, step_count);
    end
  endtask

  task automatic test_forward;
    logic [2:0] exp_h [0:5];
    logic [2:0] prev;
    int bad;
    int strobes;
    exp_h = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};
    do_reset();
    en = 1'b1; dir = 1'b1; step_period = 16'd10;
    prev = 3'b001; bad = 0; strobes = 0;
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 9; c++) begin
        tick(1);
        if (hall !== prev || step_strobe !== 1'b0) bad++;
      end
      tick(1);
      if (step_strobe === 1'b1) strobes++;
      n_checks++;
      if (hall !== exp_h[k] || step_count !== 16'(k + 1)) begin
        n_errors++;
        $display("FAIL fwd_step%0d: hall=%b count=%0d, want hall=%b count=%0d", k, hall, step_count, exp_h[k], k + 1);
      end
      prev = exp_h[k];
    end
    n_checks++;
    if (bad != 0 || strobes != 6) begin
      n_errors++;
      $display("FAIL fwd_spacing: early changes=%0d strobes=%0d, want 0 and 6", bad, strobes);
    end
  endtask

  task automatic test_direction_and_fault;
    logic [2:0]  exp_h [0:2];
    logic [15:0] exp_c [0:2];
    int bad;
    exp_h = '{3'b011, 3'b001, 3'b101};
    exp_c = '{16'd1, 16'd0, 16'hFFFF};
    do_reset();
    en = 1'b1; dir = 1'b1; step_period = 16'd10;
    tick(20);
    n_checks++;
    if (hall !== 3'b010 || step_count !== 16'd2) begin
      n_errors++;
      $display("FAIL dir_pre: hall=%b count=%0d, want 010 and 2", hall, step_count);
    end
    dir = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(10);
      n_checks++;
      if (hall !== exp_h[k] || step_count !== exp_c[k] || step_strobe !== 1'b1) begin
        n_errors++;
        $display("FAIL rev_step%0d: hall=%b count=%h strobe=%b, want %b %h 1", k, hall, step_count, step_strobe, exp_h[k], exp_c[k]);
      end
    end
    fault_mode = 2'b10;
    tick(1);
    n_checks++;
    if (hall !== 3'b111 || step_strobe !== 1'b0) begin
      n_errors++;
      $display("FAIL force_high: hall=%b strobe=%b, want 111 0", hall, step_strobe);
    end
    bad = 0;
    for (int c = 0; c < 599; c++) begin
      tick(1);
      if (hall !== 3'b111 || step_strobe !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0 || step_count !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL force_hold: bad cycles=%0d count=%h, want 0 and ffff", bad, step_count);
    end
    fault_mode = 2'b00;
    tick(1);
    n_checks++;
    if (hall !== 3'b101 || step_strobe !== 1'b0) begin
      n_errors++;
      $display("FAIL fault_restore: hall=%b strobe=%b, want 101 0", hall, step_strobe);
    end
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      if (hall !== 3'b101 || step_strobe !== 1'b0) bad++;
    end
    tick(1);
    n_checks++;
    if (bad != 0 || hall !== 3'b100 || step_count !== 16'hFFFE || step_strobe !== 1'b1) begin
      n_errors++;
      $display("FAIL fault_first_step: bad=%0d hall=%b count=%h, want 0 100 fffe", bad, hall, step_count);
    end
  endtask

  task automatic test_force_low_freeze;
    int bad;
    do_reset();
    en = 1'b1; dir = 1'b1; step_period = 16'd10;
    tick(10);
    fault_mode = 2'b01;
    tick(1);
    n_checks++;
    if (hall !== 3'b000 || step_count !== 16'd1) begin
      n_errors++;
      $display("FAIL force_low: hall=%b count=%0d, want 000 1", hall, step_count);
    end
    fault_mode = 2'b11;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      tick(1);
      if (hall !== 3'b000 || step_strobe !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL freeze_hold: bad cycles=%0d, want 0", bad);
    end
    fault_mode = 2'b00;
    tick(1);
    n_checks++;
    if (hall !== 3'b011) begin
      n_errors++;
      $display("FAIL freeze_restore: hall=%b, want 011", hall);
    end
    tick(8);
    n_checks++;
    if (hall !== 3'b011) begin
      n_errors++;
      $display("FAIL freeze_early: hall=%b, want 011", hall);
    end
    tick(1);
    n_checks++;
    if (hall !== 3'b010 || step_count !== 16'd2) begin
      n_errors++;
      $display("FAIL freeze_step: hall=%b count=%0d, want 010 2", hall, step_count);
    end
  endtask

  task automatic test_period_change;
    logic [2:0] exp_h [0:3];
    do_reset();
    en = 1'b1; dir = 1'b1; step_period = 16'd10;
    tick(4);
    step_period = 16'd3;
    tick(5);
    n_checks++;
    if (hall !== 3'b001) begin
      n_errors++;
      $display("FAIL per_early: hall=%b, want 001", hall);
    end
    tick(1);
    n_checks++;
    if (hall !== 3'b011 || step_strobe !== 1'b1) begin
      n_errors++;
      $display("FAIL per_first: hall=%b strobe=%b, want 011 1", hall, step_strobe);
    end
    tick(2);
    n_checks++;
    if (hall !== 3'b011) begin
      n_errors++;
      $display("FAIL per3_early: hall=%b, want 011", hall);
    end
    tick(1);
    n_checks++;
    if (hall !== 3'b010) begin
      n_errors++;
      $display("FAIL per3_step: hall=%b, want 010", hall);
    end
    tick(3);
    step_period = 16'd1;
    exp_h = '{3'b100, 3'b101, 3'b001, 3'b011};
    tick(3);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (hall !== exp_h[k] || step_strobe !== 1'b1 || step_count !== 16'(k + 4)) begin
        n_errors++;
        $display("FAIL per1_step%0d: hall=%b strobe=%b count=%0d, want %b 1 %0d", k, hall, step_strobe, step_count, exp_h[k], k + 4);
      end
      tick(1);
    end
  endtask

  task automatic test_terminal_races;
    do_reset();
    en = 1'b1; dir = 1'b1; step_period = 16'd4;
    tick(3);
    en = 1'b0;
    tick(3);
    n_checks++;
    if (hall !== 3'b001 || step_count !== 16'd0) begin
      n_errors++;
      $display("FAIL en_terminal: hall=%b count=%0d, want 001 0", hall, step_count);
    end
    en = 1'b1;
    tick(3);
    n_checks++;
    if (hall !== 3'b001) begin
      n_errors++;
      $display("FAIL reen_early: hall=%b, want 001", hall);
    end
    tick(1);
    n_checks++;
    if (hall !== 3'b011 || step_count !== 16'd1) begin
      n_errors++;
      $display("FAIL reen_step: hall=%b count=%0d, want 011 1", hall, step_count);
    end
    tick(3);
    fault_mode = 2'b01;
    tick(1);
    n_checks++;
    if (hall !== 3'b000 || step_strobe !== 1'b0 || step_count !== 16'd1) begin
      n_errors++;
      $display("FAIL fault_terminal: hall=%b strobe=%b count=%0d, want 000 0 1", hall, step_strobe, step_count);
    end
    fault_mode = 2'b00;
    tick(1);
    n_checks++;
    if (hall !== 3'b011) begin
      n_errors++;
      $display("FAIL fault_terminal_restore: hall=%b, want 011", hall);
    end
  endtask

  task automatic test_rst_mid;
    do_reset();
    en = 1'b1; dir = 1'b1; step_period = 16'd2;
    tick(10);
    n_checks++;
    if (hall !== 3'b101 || step_count !== 16'd5) begin
      n_errors++;
      $display("FAIL rst_pre: hall=%b count=%0d, want 101 5", hall, step_count);
    end
    tick(1);
    rst = 1'b1;
    #2;
    n_checks++;
    if (hall !== 3'b001 || step_count !== 16'd0 || step_strobe !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_async: hall=%b count=%0d strobe=%b, want 001 0 0", hall, step_count, step_strobe);
    end
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_bounce_window;
    int bad;
    logic [2:0] want;
    do_reset();
    en = 1'b1; dir = 1'b1; step_period = 16'd20;
    tick(20);
    n_checks++;
    if (hall !== 3'b011 || step_strobe !== 1'b1 || step_count !== 16'd1) begin
      n_errors++;
      $display("FAIL bounce_edge: hall=%b strobe=%b count=%0d, want 011 1 1", hall, step_strobe, step_count);
    end
    bad = 0;
    for (int k = 1; k < 20; k++) begin
      tick(1);
      want = (TB_BOUNCE && k <= 4) ? 3'b001 : 3'b011;
      if (hall !== want || step_strobe !== 1'b0 || step_count !== 16'd1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL bounce_window: bad cycles=%0d, want 0", bad);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_forward();
    test_direction_and_fault();
    test_force_low_freeze();
    test_period_change();
    test_terminal_races();
    test_rst_mid();
    test_bounce_window();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hall_emulator.md
# hall_emulator

Generates the three-wire 120° hall-effect sensor sequence a brushless motor presents to the motor controller, at a programmable step rate and direction, with forced-fault injection. It is the transmitting end of the hall interface that the BLDC driver consumes. It is used for on-board self-test and for closed-loop simulation of the BLDC driver without a motor. It also exercises the driver's hall-disconnect (3'b111) and hall-hardware-fault (3'b000) detection paths.

## Interface
Parameters:
- PERIOD_WIDTH, 16, width of step_period (clock cycles per hall step)
- COUNT_WIDTH, 16, width of the signed step position counter
- BOUNCE_CYCLES, 4, length of emulated contact bounce (used only with HALL_EMU_BOUNCE_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  run enable; 0 holds the current hall state
- dir  in  1  1 = forward sequence, 0 = reverse
- step_period  in  PERIOD_WIDTH  cycles per step; 0 = no stepping
- fault_mode  in  2  00 normal, 01 force 3'b000, 10 force 3'b111, 11 freeze
- hall  out  3  emulated hall lines, registered
- step_strobe  out  1  one-cycle pulse on each valid hall step
- step_count  out  COUNT_WIDTH  signed position: +1 per forward step, −1 per reverse step

## Operation
- Forward sequence, index 0..5: 001, 011, 010, 110, 100, 101. Reverse walks the indices downward. Index wraps 5↔0.
- States:
  - IDLE: en=0 or step_period=0.
  - RUN: en=1 and step_period≠0.
  - FORCED: fault_mode 01/10.
  - FROZEN: fault_mode 11.
- Priority: rst > fault_mode > en.
- IDLE:
  - hall holds the value for the current index.
  - Period counter cleared.
  - step_strobe=0.
- IDLE→RUN: step_period latched into the shadow register; counter starts at 0.
- RUN:
  - Counter increments each cycle.
  - When counter == shadow−1: index advances per dir, hall updates, step_strobe=1 for that cycle, step_count ±1, counter←0, shadow←step_period.
  - Changes to step_period or dir mid-step take effect only at the next step boundary. dir is sampled at the step cycle.
- FORCED:
  - hall = forced value from the cycle after fault_mode is sampled.
  - Index, counter and step_count frozen; no strobes.
- FROZEN: hall, index, counter and step_count all held.
- Return to 00:
  - hall restores to the current index value on the next cycle.
  - Counter restarts from 0, so the first step occurs a full period later.
- step_count wraps modulo 2^COUNT_WIDTH (two's complement), with no saturation.
- The two illegal hall codes 000/111 are never produced in normal mode.

## Timing
- Reset values: hall=3'b001 (index 0), step_strobe=0, step_count=0, counter=0, shadow=0, state IDLE.
- Asserting rst mid-step clears everything immediately, asynchronously.
- Step spacing in RUN is exactly step_period cycles. With step_period=1, hall steps every cycle.
- hall and step_strobe change in the same cycle. step_count reflects the new value in that same cycle.
- Deasserting en mid-step:
  - Takes effect the next cycle; the partial count is discarded.
  - On re-enable, the next step occurs step_period cycles later.
- en deasserted in the same cycle the counter hits terminal: the step does not occur.
- fault_mode≠00 in the same cycle as a terminal count: the fault wins and no step occurs.

## Configuration
- HALL_EMU_BOUNCE_EN defined:
  - On each step, the single changing hall bit first takes its new value.
  - It then reverts to the old value for BOUNCE_CYCLES cycles, then settles to the new value.
  - step_strobe marks the first edge only; step_count updates once.
  - If step_period ≤ BOUNCE_CYCLES+1, bounce is suppressed for that step.
- HALL_EMU_BOUNCE_EN not defined: clean single transitions; BOUNCE_CYCLES unused.

## Structure
- Shared motor package holds:
  - The 6-entry hall commutation table, also used by the hall decoder.
  - The illegal codes HALL_ALL_LOW=3'b000 and HALL_ALL_HIGH=3'b111.
  - The fault_mode encodings.
- One sub-module: hall_step_timer, containing the period counter, shadow register and terminal-count pulse.
- Sequencer, fault override and bounce logic live in hall_emulator.

## Test plan
- rst, then en=1, dir=1, step_period=10 → hall 001→011→010→110→100→101→001 with steps 10 cycles apart; six strobes; step_count=6.
- dir=0 after 2 forward steps → next steps 010→011→001→101; step_count goes 2→1→0→−1.
- fault_mode=10 held for 60 steps' worth of cycles → hall=111 constant with no strobes. fault_mode=00 → hall restored to the pre-fault code the next cycle, and the first step follows 10 cycles later.
- step_period changed from 10 to 3 mid-step → the current step still completes at 10 cycles; subsequent steps are 3 cycles apart. step_period=1 → a step every cycle.
- rst pulse mid-period with step_count=5 → hall=001 and step_count=0 immediately, with no strobe.
- With HALL_EMU_BOUNCE_EN and step_period=20 → on the step from 001 to 011, hall goes 011, then 001 for 4 cycles, then 011; exactly one strobe; step_count increments by 1.
